data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Controller in front of the single-port `Data_Mem` (64 x 8, synchronous write, combinational read) that shares it between two requesters: port 0, the core load/store path, and port 1, the loader/debug path. After reset it runs a clear sequence that writes zero to every memory location. It then arbitrates single-cycle read/write accesses round-robin and returns registered read data to the winning port.

## Interface
- `ADDR_W`, default 6: memory address width; depth is 2^ADDR_W.
- `DATA_W`, default 8: memory data width.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  access request; held high until the matching grant.
- `we0` / `we1`  in  1  access type: 1 = write, 0 = read; valid while `reqN` is high.
- `addr0` / `addr1`  in  ADDR_W  access address.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `gnt0` / `gnt1`  out  1  combinational grant; the access executes in the cycle `gntN` is high.
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse; `rdataN` is valid.
- `rdata0` / `rdata1`  out  DATA_W  registered read data; holds its value until the next read for that port.
- `mem_addr`  out  ADDR_W  to `Data_Mem.addr`.
- `mem_wdata`  out  DATA_W  to `Data_Mem.data_in`.
- `mem_write`  out  1  to `Data_Mem.mem_write`.
- `mem_rdata`  in  DATA_W  from `Data_Mem.data_out`.
- `init_done`  out  1  high once the clear sequence has completed.

## Operation
- States: CLEAR and RUN. Reset enters CLEAR.
- CLEAR:
  - `mem_write`=1, `mem_addr`=`clr_cnt`, `mem_wdata`=0.
  - `clr_cnt` resets to 0 and increments on each edge.
  - At the edge where `clr_cnt`=2^ADDR_W-1, go to RUN, set `init_done`=1 and return `clr_cnt` to 0.
  - `gnt0`/`gnt1` stay 0; requests are held off, not dropped.
- RUN, grant rule (at most one grant per cycle):
  - Only one `reqN` high: grant that port.
  - Both high: grant the port not granted most recently.
  - Last-winner pointer is updated only on a grant. Its reset value makes port 0 win the first contention.
- Granted access:
  - `mem_addr`=`addrN`, `mem_wdata`=`wdataN`, `mem_write`=`weN`.
  - Reads sample `mem_rdata` into `rdataN` at the end of the grant cycle and pulse `rvalidN` for the following cycle.
  - Writes produce no `rvalid`.
- No grant in RUN: `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- A requester seeing `gntN` high may present a new request, or drop `reqN`, from the next cycle. Back-to-back grants to the same port are legal when the other port is idle.
- Read-after-write to the same address, in consecutive grants from either port: the read returns the newly written data, because the memory write commits at the grant edge.

## Timing
- Reset values (while `rst`=0):
  - `gnt0`, `gnt1`, `rvalid0`, `rvalid1`, `init_done`: 0.
  - `rdata0`, `rdata1`: 0.
  - `mem_write`: forced 0.
  - `clr_cnt`: 0; state CLEAR; pointer set so port 0 wins first.
- Clear length is 2^ADDR_W cycles (64 by default). `init_done` rises after the 64th rising edge following reset release, and the first grant can occur in that same following cycle.
- Grant latency: 0 cycles (combinational from `reqN` and state). Read data latency: 1 cycle after the grant.
- Sustained throughput is one access per cycle. Under continuous contention, each port gets every other cycle.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately, and a pending `rvalid` is lost.
  - After release, CLEAR restarts from address 0, whether reset hit during RUN or part-way through CLEAR.
- Changing `weN`/`addrN`/`wdataN` while `reqN` is high and ungranted is allowed; the values sampled in the grant cycle are used.

## Test plan
- Reset pulse, then idle: `mem_write`=1 for exactly 64 cycles with `mem_addr` stepping 0..63 and `mem_wdata`=0. `init_done` rises after edge 64. A later port 0 read of address 10 returns `rdata0`=0 with a single-cycle `rvalid0`.
- Port 0 writes 30 to address 10 (`gnt0` in the same cycle, `mem_write`=1), then reads address 10: `rvalid0` one cycle after the grant with `rdata0`=30. `rvalid1` stays 0 throughout.
- `req0` and `req1` held high for 6 cycles, both reads: grants go 0,1,0,1,0,1. `rvalid` pulses follow each grant by one cycle with the correct port's data.
- Same cycle, first contention after reset: port 1 writes 47 to address 32 while port 0 reads address 32. Port 0 is granted first and returns 0. The port 1 write follows in the next cycle, and a subsequent port 0 read returns 47.
- `req1` raised at clear cycle 5 to write 49 to address 48: `gnt1` stays 0 through CLEAR and asserts in the first RUN cycle. Address 48 then reads 49, not 0.
- `rst` pulled low for 2 cycles at clear cycle 20, and again while a read is granted in RUN: all outputs go to 0 immediately and the pending `rvalid` never appears. CLEAR restarts at `mem_addr`=0 and runs a full 64 cycles.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that shares a single-port Data_Mem between the core (port 0)
// and the loader/debug path (port 1), with a power-on clear of the whole memory.
module data_mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic              i_req1,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_write,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_init_done
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam logic [ADDR_W-1:0] CLR_LAST = {ADDR_W{1'b1}};

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_last;        // port that won the most recent grant
    logic              r_init_done;

    logic              w_run;
    logic [1:0]        w_gnt;
    logic [1:0]        w_rd;

    assign w_run = (r_state == ST_RUN);

    // On contention the port that did not win last time gets the memory.
    assign w_gnt[0] = w_run & i_req0 & (~i_req1 | r_last);
    assign w_gnt[1] = w_run & i_req1 & (~i_req0 | ~r_last);
    assign w_rd[0]  = w_gnt[0] & ~i_we0;
    assign w_rd[1]  = w_gnt[1] & ~i_we1;

    assign o_gnt0      = w_gnt[0];
    assign o_gnt1      = w_gnt[1];
    assign o_init_done = r_init_done;

    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_write = 1'b0;
        if (!w_run) begin
            // Clear writes are suppressed while reset is held.
            o_mem_write = i_rst_n;
            o_mem_addr  = r_clr_cnt;
        end else if (w_gnt[0]) begin
            o_mem_write = i_we0;
            o_mem_addr  = i_addr0;
            o_mem_wdata = i_wdata0;
        end else if (w_gnt[1]) begin
            o_mem_write = i_we1;
            o_mem_addr  = i_addr1;
            o_mem_wdata = i_wdata1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_CLEAR;
            r_clr_cnt   <= '0;
            r_init_done <= 1'b0;
            r_last      <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_cnt == CLR_LAST) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                        r_clr_cnt   <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_gnt[0]) begin
                        r_last <= 1'b0;
                    end else if (w_gnt[1]) begin
                        r_last <= 1'b1;
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic              r_rvalid;
            logic [DATA_W-1:0] r_rdata;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_rvalid <= 1'b0;
                    r_rdata  <= '0;
                end else begin
                    r_rvalid <= w_rd[gi];
                    if (w_rd[gi]) begin
                        r_rdata <= i_mem_rdata;
                    end
                end
            end
        end
    endgenerate

    assign o_rvalid0 = g_port[0].r_rvalid;
    assign o_rvalid1 = g_port[1].r_rvalid;
    assign o_rdata0  = g_port[0].r_rdata;
    assign o_rdata1  = g_port[1].r_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the two requesters and the memory contents.
module tb_data_mem_arbiter;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_write, init_done;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] mem [DEPTH];
    int            errors = 0;
    int            checks = 0;

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
        .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
        .o_gnt0(gnt0), .o_gnt1(gnt1),
        .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
        .o_rdata0(rdata0), .o_rdata1(rdata1),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_write(mem_write),
        .i_mem_rdata(mem_rdata), .o_init_done(init_done)
    );

    always #5 clk = ~clk;

    // Data_Mem: garbage at power-up so a missing clear shows up on later reads.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        forever begin
            @(posedge clk);
            if (mem_write) mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Called just after reset release; walks the full clear and the first RUN cycle.
    task automatic test_clear_sequence(input string name);
        logic [AW-1:0] ka;
        for (int k = 0; k < DEPTH; k++) begin
            ka = AW'(k);
            #3;
            checks++;
            if ({mem_write, mem_addr, mem_wdata, init_done, gnt0, gnt1} !== {1'b1, ka, 8'h00, 3'b000}) begin
                errors++;
                $display("FAIL %s cycle %0d: we=%b addr=%0d wdata=%0d done=%b gnt=%b%b, want 1 %0d 0 0 00",
                         name, k, mem_write, mem_addr, mem_wdata, init_done, gnt0, gnt1, k);
            end
            tick();
        end
        #3;
        checks++;
        if (init_done !== 1'b1 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL %s_end: init_done=%b mem_write=%b, want 1 0", name, init_done, mem_write);
        end
        tick();
    endtask

    task automatic test_reset();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, init_done, mem_write} !== 6'b0 || rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: gnt=%b%b rv=%b%b done=%b we=%b rd0=%0d rd1=%0d, want all 0",
                     gnt0, gnt1, rvalid0, rvalid1, init_done, mem_write, rdata0, rdata1);
        end
        tick();
        rst_n = 1'b1;
        test_clear_sequence("clear_after_reset");
    endtask

    task automatic test_first_contention();
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd32;
        req1 = 1'b1; we1 = 1'b1; addr1 = 6'd32; wdata1 = 8'd47;
        #3;
        checks++;
        if ({gnt0, gnt1, mem_write} !== 3'b100 || mem_addr !== 6'd32) begin
            errors++;
            $display("FAIL contention_first_grant: gnt=%b%b we=%b addr=%0d, want 10 0 32", gnt0, gnt1, mem_write, mem_addr);
        end
        tick();
        req0 = 1'b0;
        #3;
        checks++;
        if ({gnt0, gnt1, mem_write} !== 3'b011 || mem_addr !== 6'd32 || mem_wdata !== 8'd47) begin
            errors++;
            $display("FAIL contention_second_grant: gnt=%b%b we=%b addr=%0d wdata=%0d, want 01 1 32 47",
                     gnt0, gnt1, mem_write, mem_addr, mem_wdata);
        end
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'd0) begin
            errors++;
            $display("FAIL contention_read_old: rvalid0=%b rdata0=%0d, want 1 0", rvalid0, rdata0);
        end
        tick();
        req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 6'd32;
        #3;
        checks++;
        if (gnt0 !== 1'b1 || rvalid1 !== 1'b0 || rvalid0 !== 1'b0) begin
            errors++;
            $display("FAIL contention_reread_grant: gnt0=%b rv=%b%b, want 1 00", gnt0, rvalid0, rvalid1);
        end
        tick();
        req0 = 1'b0;
        #3;
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'd47) begin
            errors++;
            $display("FAIL contention_read_new: rvalid0=%b rdata0=%0d, want 1 47", rvalid0, rdata0);
        end
        tick();
    endtask

    task automatic test_read_cleared();
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd10;
        #3;
        checks++;
        if (gnt0 !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 6'd10) begin
            errors++;
            $display("FAIL read10_grant: gnt0=%b we=%b addr=%0d, want 1 0 10", gnt0, mem_write, mem_addr);
        end
        tick();
        req0 = 1'b0;
        #3;
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'd0) begin
            errors++;
            $display("FAIL read10_data: rvalid0=%b rdata0=%0d, want 1 0", rvalid0, rdata0);
        end
        tick();
        #3;
        checks++;
        if (rvalid0 !== 1'b0 || rdata0 !== 8'd0) begin
            errors++;
            $display("FAIL read10_pulse: rvalid0=%b rdata0=%0d, want 0 0 (held)", rvalid0, rdata0);
        end
        tick();
    endtask

    task automatic test_write_read();
        req0 = 1'b1; we0 = 1'b1; addr0 = 6'd10; wdata0 = 8'd30;
        #3;
        checks++;
        if (gnt0 !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 6'd10 || mem_wdata !== 8'd30) begin
            errors++;
            $display("FAIL write30_grant: gnt0=%b we=%b addr=%0d wdata=%0d, want 1 1 10 30",
                     gnt0, mem_write, mem_addr, mem_wdata);
        end
        tick();
        we0 = 1'b0;
        #3;
        checks++;
        if (gnt0 !== 1'b1 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            errors++;
            $display("FAIL write30_no_rvalid: gnt0=%b rv=%b%b, want 1 00", gnt0, rvalid0, rvalid1);
        end
        tick();
        req0 = 1'b0;
        #3;
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'd30 || rvalid1 !== 1'b0) begin
            errors++;
            $display("FAIL write30_readback: rv=%b%b rdata0=%0d, want 10 30", rvalid0, rvalid1, rdata0);
        end
        tick();
        // Port 1 write leaves port 1 as last winner for the alternation test.
        req1 = 1'b1; we1 = 1'b1; addr1 = 6'd5; wdata1 = 8'h5a;
        #3;
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_write !== 1'b1 || mem_addr !== 6'd5 || mem_wdata !== 8'h5a) begin
            errors++;
            $display("FAIL write5a_port1: gnt=%b%b we=%b addr=%0d wdata=%0h, want 01 1 5 5a",
                     gnt0, gnt1, mem_write, mem_addr, mem_wdata);
        end
        tick();
        req1 = 1'b0;
        #3;
        checks++;
        if (rvalid1 !== 1'b0 || rvalid0 !== 1'b0) begin
            errors++;
            $display("FAIL write5a_no_rvalid: rv=%b%b, want 00", rvalid0, rvalid1);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd32;
        req1 = 1'b1; we1 = 1'b0; addr1 = 6'd10;
        for (int i = 0; i <= 6; i++) begin
            if (i == 6) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            #3;
            if (i < 6) begin
                checks++;
                if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL alternate_grant %0d: gnt=%b%b, want %s", i, gnt0, gnt1, (i % 2 == 0) ? "10" : "01");
                end
            end
            if (i > 0) begin
                checks++;
                if ((i % 2 == 1) ? ({rvalid0, rvalid1} !== 2'b10 || rdata0 !== 8'd47)
                                 : ({rvalid0, rvalid1} !== 2'b01 || rdata1 !== 8'd30)) begin
                    errors++;
                    $display("FAIL alternate_data %0d: rv=%b%b rd0=%0d rd1=%0d, want port %0d data %0d",
                             i, rvalid0, rvalid1, rdata0, rdata1, (i - 1) % 2, (i % 2 == 1) ? 47 : 30);
                end
            end
            tick();
        end
    endtask

    task automatic test_req_during_clear();
        logic [AW-1:0] ka;
        apply_reset();
        for (int k = 0; k < DEPTH; k++) begin
            ka = AW'(k);
            if (k == 5) begin
                req1 = 1'b1; we1 = 1'b1; addr1 = 6'd48; wdata1 = 8'd49;
            end
            #3;
            checks++;
            if (gnt1 !== 1'b0 || mem_addr !== ka || mem_wdata !== 8'd0) begin
                errors++;
                $display("FAIL held_off_clear %0d: gnt1=%b addr=%0d wdata=%0d, want 0 %0d 0", k, gnt1, mem_addr, mem_wdata, k);
            end
            tick();
        end
        #3;
        checks++;
        if (gnt1 !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 6'd48 || mem_wdata !== 8'd49 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL held_off_first_run: gnt1=%b we=%b addr=%0d wdata=%0d done=%b, want 1 1 48 49 1",
                     gnt1, mem_write, mem_addr, mem_wdata, init_done);
        end
        tick();
        req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 6'd48;
        #3;
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL held_off_read_grant: gnt0=%b, want 1", gnt0);
        end
        tick();
        req0 = 1'b0;
        #3;
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'd49) begin
            errors++;
            $display("FAIL held_off_readback: rvalid0=%b rdata0=%0d, want 1 49", rvalid0, rdata0);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        apply_reset();
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_write, init_done, gnt0, gnt1, rvalid0, rvalid1} !== 6'b0 || rdata0 !== 8'd0 || rdata1 !== 8'd0) begin
            errors++;
            $display("FAIL midclear_reset: we=%b done=%b gnt=%b%b rv=%b%b rd0=%0d rd1=%0d, want all 0",
                     mem_write, init_done, gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1);
        end
        tick();
        tick();
        rst_n = 1'b1;
        test_clear_sequence("clear_after_midclear");
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd48;
        #3;
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL midrun_grant: gnt0=%b, want 1", gnt0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, mem_write, init_done, rvalid0, rvalid1} !== 6'b0) begin
            errors++;
            $display("FAIL midrun_reset: gnt=%b%b we=%b done=%b rv=%b%b, want all 0",
                     gnt0, gnt1, mem_write, init_done, rvalid0, rvalid1);
        end
        tick();
        tick();
        rst_n = 1'b1;
        req0 = 1'b0;
        #3;
        checks++;
        if (rvalid0 !== 1'b0 || rdata0 !== 8'd0) begin
            errors++;
            $display("FAIL midrun_lost_rvalid: rvalid0=%b rdata0=%0d, want 0 0", rvalid0, rdata0);
        end
        test_clear_sequence("clear_after_midrun");
    endtask

    // Two requesters that hold each request until granted; the model tracks memory
    // contents, who won last, and what each port should see on its read return.
    task automatic test_random();
        logic [DW-1:0] ref_mem [DEPTH];
        bit            p0 = 0, p1 = 0;
        int            last_win = 1;
        int            w;
        bit            ev0 = 0, ev1 = 0;
        logic [DW-1:0] ed0 = '0, ed1 = '0;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        apply_reset();
        repeat (DEPTH) tick();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        for (int c = 0; c < 400; c++) begin
            if (!p0 && $urandom_range(1, 0) == 1) p0 = 1;
            if (p0 && (!req0 || $urandom_range(3, 0) == 0)) begin
                we0 = 1'($urandom_range(1, 0)); addr0 = AW'($urandom_range(7, 0)); wdata0 = DW'($urandom);
            end
            if (!p1 && $urandom_range(1, 0) == 1) p1 = 1;
            if (p1 && (!req1 || $urandom_range(3, 0) == 0)) begin
                we1 = 1'($urandom_range(1, 0)); addr1 = AW'($urandom_range(7, 0)); wdata1 = DW'($urandom);
            end
            req0 = p0;
            req1 = p1;
            #3;
            if (p0 && p1)  w = 1 - last_win;
            else if (p0)   w = 0;
            else if (p1)   w = 1;
            else           w = -1;
            e_we   = (w == 0) ? we0    : (w == 1) ? we1    : 1'b0;
            e_addr = (w == 0) ? addr0  : (w == 1) ? addr1  : '0;
            e_wd   = (w == 0) ? wdata0 : (w == 1) ? wdata1 : '0;
            checks++;
            if ({gnt0, gnt1} !== {w == 0, w == 1} || mem_write !== e_we || mem_addr !== e_addr || mem_wdata !== e_wd) begin
                errors++;
                $display("FAIL random_bus cyc %0d: gnt=%b%b we=%b addr=%0d wd=%0d, want winner %0d we=%b addr=%0d wd=%0d",
                         c, gnt0, gnt1, mem_write, mem_addr, mem_wdata, w, e_we, e_addr, e_wd);
            end
            checks++;
            if (rvalid0 !== ev0 || rdata0 !== ed0 || rvalid1 !== ev1 || rdata1 !== ed1) begin
                errors++;
                $display("FAIL random_rdata cyc %0d: rv=%b%b rd0=%0d rd1=%0d, want rv=%b%b rd0=%0d rd1=%0d",
                         c, rvalid0, rvalid1, rdata0, rdata1, ev0, ev1, ed0, ed1);
            end
            ev0 = (w == 0) && !we0;
            ev1 = (w == 1) && !we1;
            if (ev0) ed0 = ref_mem[addr0];
            if (ev1) ed1 = ref_mem[addr1];
            if (w >= 0) begin
                if (e_we) ref_mem[e_addr] = e_wd;
                last_win = w;
                if (w == 0) p0 = 0; else p1 = 0;
            end
            tick();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        #3;
        checks++;
        if (rvalid0 !== ev0 || rdata0 !== ed0 || rvalid1 !== ev1 || rdata1 !== ed1) begin
            errors++;
            $display("FAIL random_tail: rv=%b%b rd0=%0d rd1=%0d, want rv=%b%b rd0=%0d rd1=%0d",
                     rvalid0, rvalid1, rdata0, rdata1, ev0, ev1, ed0, ed1);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_first_contention();
        test_read_cleared();
        test_write_read();
        test_back_to_back();
        test_req_during_clear();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
